// File: rtl/debounce_switch_pair.sv
// rtl/debounce_switch_pair.sv - two independent switch debouncers with 2-flop synchronizers; optional press pulse under DEBOUNCE_PULSE_EN
module debounce_switch_pair #(
    parameter int DEBOUNCE_LIMIT = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
`ifdef DEBOUNCE_PULSE_EN
    output logic o_Press_1,
    output logic o_Press_2,
`endif
    output logic o_Switch_1,
    output logic o_Switch_2
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(DEBOUNCE_LIMIT - 1);

    // A limit below 2 leaves no room for a counter and makes the debounce meaningless.
    if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
        $error("debounce_switch_pair: DEBOUNCE_LIMIT must be at least 2");
    end

    // Bit 0 is channel 1, bit 1 is channel 2 throughout.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
`ifdef DEBOUNCE_PULSE_EN
    logic [1:0]       press_q, press_d;
`endif

    // Synchronize raw inputs, then run each channel's mismatch counter; the state only
    // flips after DEBOUNCE_LIMIT consecutive mismatching samples.
    always_comb begin
        sync1_d = {i_Switch_2, i_Switch_1};
        sync2_d = sync1_q;
        state_d = state_q;
`ifdef DEBOUNCE_PULSE_EN
        press_d = 2'b00;
`endif
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = '0;
            if (sync2_q[ch] != state_q[ch]) begin
                if (cnt_q[ch] == LIMIT_M1) begin
                    state_d[ch] = sync2_q[ch];
`ifdef DEBOUNCE_PULSE_EN
                    press_d[ch] = sync2_q[ch];
`endif
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                end
            end
        end
    end

    // All state registers, cleared asynchronously so a reset mid-count discards it.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
`ifdef DEBOUNCE_PULSE_EN
            press_q  <= '0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
`ifdef DEBOUNCE_PULSE_EN
            press_q  <= press_d;
`endif
        end
    end

    assign o_Switch_1 = state_q[0];
    assign o_Switch_2 = state_q[1];
`ifdef DEBOUNCE_PULSE_EN
    assign o_Press_1  = press_q[0];
    assign o_Press_2  = press_q[1];
`endif

endmodule

// File: doc/debounce_switch_pair.md
DEBOUNCE_SWITCH_PAIR -- requirements
Module: debounce_switch_pair

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_LIMIT, default 250000, giving the consecutive stable-mismatch cycles required before an output changes (10 ms at 25 MHz).
REQ-002 DEBOUNCE_LIMIT SHALL be at least 2; the counter width SHALL be $clog2(DEBOUNCE_LIMIT).
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The block SHALL have port i_Rst_L, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_Switch_1, input, 1 bit: raw, asynchronous, bouncing switch 1.
REQ-006 The block SHALL have port i_Switch_2, input, 1 bit: raw, asynchronous, bouncing switch 2.
REQ-007 The block SHALL have port o_Switch_1, output, 1 bit: debounced switch 1, which feeds the downstream AND-gate stage.
REQ-008 The block SHALL have port o_Switch_2, output, 1 bit: debounced switch 2, which feeds the downstream AND-gate stage.
REQ-009 The block SHALL have ports o_Press_1 and o_Press_2, output, 1 bit each, present only with DEBOUNCE_PULSE_EN (REQ-021).

Function
REQ-010 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1 then sync2) before any other logic uses it.
REQ-011 Each channel SHALL hold a state register (driving o_Switch_n) and an up-counter; the two channels SHALL be fully independent.
REQ-012 Each cycle, when sync2 equals the state, the counter SHALL load 0.
REQ-013 Each cycle, when sync2 differs from the state and the counter is below DEBOUNCE_LIMIT-1, the counter SHALL increment by 1.
REQ-014 Each cycle, when sync2 differs from the state and the counter equals DEBOUNCE_LIMIT-1, the state SHALL take sync2 and the counter SHALL load 0.
REQ-015 Latency SHALL be exactly 2 + DEBOUNCE_LIMIT rising edges from a stable raw edge (sampled at an edge) to the o_Switch_n change.
REQ-016 Any return of sync2 to the state value before the limit SHALL abort the count with no output change (glitch rejection), and a later mismatch SHALL restart from 0.
REQ-017 The counter SHALL never exceed DEBOUNCE_LIMIT-1 and SHALL never wrap.
REQ-018 Simultaneous transitions on both channels SHALL be processed independently, with identical latency.
REQ-019 Outputs SHALL be registered with no combinational path from any input to any output.

Reset
REQ-020 While i_Rst_L=0, asynchronously: synchronizer flops, states and counters SHALL be 0; o_Switch_1, o_Switch_2, o_Press_1 and o_Press_2 SHALL be 0. An assertion mid-count SHALL discard the count. After release, a raw input held at 1 SHALL produce o_Switch_n=1 after 2 + DEBOUNCE_LIMIT edges.

Configuration
REQ-021 With macro DEBOUNCE_PULSE_EN defined, o_Press_n SHALL pulse high for exactly 1 cycle, on the same edge that o_Switch_n goes 0->1; it SHALL NOT pulse on 1->0 transitions.
REQ-022 Without DEBOUNCE_PULSE_EN, the o_Press ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DEBOUNCE_LIMIT=4, 10 ns clock)
REQ-023 Scenario 1: hold i_Rst_L=0, toggle both switches -> all outputs stay 0. Release reset with inputs at 0 -> outputs stay 0.
REQ-024 Scenario 2: set i_Switch_1 0->1 and hold -> o_Switch_1 rises exactly 6 edges later; o_Switch_2 stays 0. With DEBOUNCE_PULSE_EN, o_Press_1 is high for exactly that one cycle.
REQ-025 Scenario 3: apply 1-, 2- and 3-cycle high glitches on i_Switch_2, separated by 3+ low cycles -> o_Switch_2 never changes and o_Press_2 never fires.
REQ-026 Scenario 4: both switches 0->1 on the same edge -> both outputs rise on the same edge, 6 edges later (AND-gate consumer sees 1). Then switch 1 goes 1->0 -> o_Switch_1 falls 6 edges later with no press pulse.
REQ-027 Scenario 5: i_Switch_1 goes high; drive i_Rst_L low for one cycle at count 2 -> outputs 0, and o_Switch_1 rises 6 edges after reset release.
REQ-028 Scenario 6: random bounce for 20 cycles, then stable 1 -> exactly one 0->1 on o_Switch_1, occurring 6 edges after the final bounce edge.
